instr_buffer: RTL

INSTR_BUFFER -- requirements
Module: instr_buffer

---
 rtl/instr_buffer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/instr_buffer.sv
// instr_buffer: circular instruction buffer between fetch and decode.
//
// Fetch side offers a group of INSTR_PER_FETCH slots with a per-slot valid
// mask; the valid slots are packed into consecutive entries at the tail.
// Decode side sees up to DECODE_WIDTH of the oldest entries each cycle and
// reports how many it consumed through dec_accept_i.
//
// Ports
//   clk_i, rst_ni              clock, async active-low reset
//   flush_i                    drop all contents at the next edge
//   fetch_valid_i/_ready_o     group handshake (ready = room for a full group)
//   fetch_pc_i                 PC of slot 0; slot k sits at PC + 4*k
//   fetch_instrs_i             slot k in bits [k*ILEN +: ILEN]
//   fetch_slot_valid_i         per-slot valid mask
//   dec_valid_o                thermometer lane valids, lane 0 oldest
//   dec_instr_o, dec_pc_o      lane data, zero on invalid lanes
//   dec_accept_i               lanes consumed this cycle (clipped)
//   count_o                    occupied entries

// Per-lane output stage: forces data to zero on an empty lane.
module instr_buffer_lane #(
  parameter int ILEN = 32,
  parameter int XLEN = 32
) (
  input  logic            valid_i,
  input  logic [ILEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            valid_o,
  output logic [ILEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o
);
  assign valid_o = valid_i;
  assign instr_o = valid_i ? instr_i : '0;
  assign pc_o    = valid_i ? pc_i    : '0;
endmodule

module instr_buffer #(
  parameter int INSTR_PER_FETCH = 4,
  parameter int DECODE_WIDTH    = 2,
  parameter int ILEN            = 32,
  parameter int XLEN            = 32,
  parameter int DEPTH           = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              flush_i,
  input  logic                              fetch_valid_i,
  output logic                              fetch_ready_o,
  input  logic [XLEN-1:0]                   fetch_pc_i,
  input  logic [INSTR_PER_FETCH*ILEN-1:0]   fetch_instrs_i,
  input  logic [INSTR_PER_FETCH-1:0]        fetch_slot_valid_i,
  output logic [DECODE_WIDTH-1:0]           dec_valid_o,
  output logic [DECODE_WIDTH*ILEN-1:0]      dec_instr_o,
  output logic [DECODE_WIDTH*XLEN-1:0]      dec_pc_o,
  input  logic [$clog2(DECODE_WIDTH+1)-1:0] dec_accept_i,
  output logic [$clog2(DEPTH+1)-1:0]        count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0][ILEN-1:0] instr_q, instr_d;
  logic [DEPTH-1:0][XLEN-1:0] pc_q, pc_d;
  logic [PW-1:0]              head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]              count_q, count_d;

  logic          do_enq;
  logic [CW-1:0] enq_cnt, avail, deq_cnt;
  logic [PW-1:0] widx;

  // Credit comes from registered count only, so a same-cycle dequeue never
  // opens room for the group being offered.
  assign fetch_ready_o = (CW'(DEPTH) - count_q) >= CW'(INSTR_PER_FETCH);
  assign do_enq        = fetch_valid_i && fetch_ready_o && !flush_i;
  assign count_o       = count_q;

  // Lanes that currently hold data; accept beyond this is clipped.
  assign avail   = (count_q > CW'(DECODE_WIDTH)) ? CW'(DECODE_WIDTH) : count_q;
  assign deq_cnt = (CW'(dec_accept_i) < avail) ? CW'(dec_accept_i) : avail;

  // Compact valid slots into tail, tail+1, ... in ascending slot order.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    enq_cnt = '0;
    widx    = '0;
    for (int k = 0; k < INSTR_PER_FETCH; k++) begin
      if (do_enq && fetch_slot_valid_i[k]) begin
        widx          = tail_q + enq_cnt[PW-1:0];
        instr_d[widx] = fetch_instrs_i[k*ILEN +: ILEN];
        pc_d[widx]    = fetch_pc_i + XLEN'(4*k);
        enq_cnt       = enq_cnt + CW'(1);
      end
    end
  end

  always_comb begin
    head_d  = head_q + deq_cnt[PW-1:0];
    tail_d  = tail_q + enq_cnt[PW-1:0];
    count_d = count_q + enq_cnt - deq_cnt;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instr_q <= '0;
      pc_q    <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Read lanes straight from stored state; no bypass from the fetch side.
  for (genvar i = 0; i < DECODE_WIDTH; i++) begin : g_lane
    logic [PW-1:0] rd_idx;
    assign rd_idx = head_q + PW'(i);
    instr_buffer_lane #(.ILEN(ILEN), .XLEN(XLEN)) u_lane (
      .valid_i (count_q > CW'(i)),
      .instr_i (instr_q[rd_idx]),
      .pc_i    (pc_q[rd_idx]),
      .valid_o (dec_valid_o[i]),
      .instr_o (dec_instr_o[i*ILEN +: ILEN]),
      .pc_o    (dec_pc_o[i*XLEN +: XLEN])
    );
  end
endmodule
